// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-aware arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are combinational (zero-latency accept); FULL stalls a burst without consuming its length.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int REQ_BITS   = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic                          WR_EN,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  input  logic                          FULL,
  output logic                          BUSY,
  output logic [REQ_BITS-1:0]           OWNER
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam int SUM_W = REQ_BITS + 1;
  typedef logic [SUM_W-1:0] sum_t;

  state_t              state_q, state_d;
  logic [REQ_BITS-1:0] ptr_q, ptr_d;
  logic [REQ_BITS-1:0] owner_q, owner_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic [7:0]          bcnt_inc;

  logic                win_found;
  logic [REQ_BITS-1:0] win_idx;
  logic                grant;
  logic [REQ_BITS-1:0] gnt_idx;

  function automatic logic [REQ_BITS-1:0] wrap_inc(input logic [REQ_BITS-1:0] x);
    return (x == REQ_BITS'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // Scan from the farthest offset down so the nearest requester to ptr_q wins last.
  always_comb begin
    sum_t                sum;
    logic [REQ_BITS-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + sum_t'(k);
      if (sum >= sum_t'(NUM_REQ)) sum = sum - sum_t'(NUM_REQ);
      cand = sum[REQ_BITS-1:0];
      if (REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign bcnt_inc = bcnt_q + 8'd1;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    grant   = 1'b0;
    gnt_idx = '0;
    if (!RESET) begin
      unique case (state_q)
        IDLE: begin
          if (win_found && !FULL) begin
            grant   = 1'b1;
            gnt_idx = win_idx;
            if (MAX_BURST == 1) begin
              ptr_d = wrap_inc(win_idx);
            end else begin
              state_d = BURST;
              owner_d = win_idx;
              bcnt_d  = 8'd1;
            end
          end
        end
        BURST: begin
          if (REQ[owner_q]) begin
            if (!FULL) begin
              grant   = 1'b1;
              gnt_idx = owner_q;
              bcnt_d  = bcnt_inc;
              if (bcnt_inc == 8'(MAX_BURST)) begin
                state_d = IDLE;
                ptr_d   = wrap_inc(owner_q);
              end
            end
          end else begin
            // Owner withdrew: give up the port with a one-cycle bubble.
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    GNT     = '0;
    WR_DATA = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      GNT[i] = grant && (gnt_idx == REQ_BITS'(i));
      if (GNT[i]) WR_DATA = WR_DATA | REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign WR_EN = |GNT;
  assign BUSY  = (state_q == BURST);
  assign OWNER = owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a vector table for per-cycle behaviour plus
// hand-written sequences for backpressure, reset mid-burst and MAX_BURST=1.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        full;

  logic [3:0]  gnt, gnt1;
  logic        wr_en, wr_en1;
  logic [3:0]  wr_data, wr_data1;
  logic        busy, busy1;
  logic [1:0]  owner, owner1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .REQ_BITS(2), .MAX_BURST(4)) dut (
    .CLOCK(clk), .RESET(rst), .REQ(req), .REQ_DATA(req_data), .GNT(gnt),
    .WR_EN(wr_en), .WR_DATA(wr_data), .FULL(full), .BUSY(busy), .OWNER(owner)
  );

  fifo_write_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .REQ_BITS(2), .MAX_BURST(1)) dut1 (
    .CLOCK(clk), .RESET(rst), .REQ(req), .REQ_DATA(req_data), .GNT(gnt1),
    .WR_EN(wr_en1), .WR_DATA(wr_data1), .FULL(full), .BUSY(busy1), .OWNER(owner1)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] data;
    logic        full;
    logic [3:0]  gnt;
    logic [3:0]  wr_data;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] q, input logic [15:0] d, input logic f,
                     input logic [3:0] g, input logic [3:0] wd, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.data = d; v.full = f; v.gnt = g; v.wr_data = wd; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic apply(input logic r, input logic [3:0] q, input logic [15:0] d, input logic f);
    @(negedge clk);
    rst = r; req = q; req_data = d; full = f;
    #1;
  endtask

  task automatic check_main(input string tag, input logic [3:0] g, input logic [3:0] wd, input logic b);
    check({tag, " gnt"}, 32'(gnt), 32'(g));
    check({tag, " wr_en"}, 32'(wr_en), 32'(|g));
    check({tag, " wr_data"}, 32'(wr_data), 32'(wd));
    check({tag, " busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; full = 1'b0;
    repeat (2) @(negedge clk);

    // Reset forces the grant path off even with every producer requesting.
    add(1, 4'b1111, 16'hDCBA, 0, 4'b0000, 4'h0, 0);

    // Single producer, long request: bursts of 4 with no bubble between them.
    add(0, 4'b0100, 16'h0100, 0, 4'b0100, 4'h1, 0);
    add(0, 4'b0100, 16'h0200, 0, 4'b0100, 4'h2, 1);
    add(0, 4'b0100, 16'h0300, 0, 4'b0100, 4'h3, 1);
    add(0, 4'b0100, 16'h0400, 0, 4'b0100, 4'h4, 1);
    add(0, 4'b0100, 16'h0500, 0, 4'b0100, 4'h5, 0);
    add(0, 4'b0100, 16'h0600, 0, 4'b0100, 4'h6, 1);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 1);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 0);
    add(1, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 0);

    // All producers saturating: 0x4, 1x4, 2x4, 3x4, then 0 again.
    for (int i = 0; i < 16; i++)
      add(0, 4'b1111, 16'hDCBA, 0, 4'(1 << (i / 4)), 4'(4'hA + i / 4), (i % 4) != 0);
    add(0, 4'b1111, 16'hDCBA, 0, 4'b0001, 4'hA, 0);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 1);
    add(1, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 0);

    // Early release: producer 0 drops after 2 words, one bubble, then producer 1.
    add(0, 4'b0011, 16'h0065, 0, 4'b0001, 4'h5, 0);
    add(0, 4'b0011, 16'h0065, 0, 4'b0001, 4'h5, 1);
    add(0, 4'b0010, 16'h0065, 0, 4'b0000, 4'h0, 1);
    add(0, 4'b0010, 16'h0065, 0, 4'b0010, 4'h6, 0);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 1);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 0);

    // FULL blocks a grant in IDLE; a release in BURST happens even with FULL high.
    add(0, 4'b0001, 16'h0065, 1, 4'b0000, 4'h0, 0);
    add(0, 4'b0001, 16'h0065, 0, 4'b0001, 4'h5, 0);
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 4'h0, 1);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].full);
      check_main($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].wr_data, vecs[i].busy);
    end

    // Backpressure mid-burst: producer 1 owns, FULL for 3 cycles after its 2nd word.
    check("bp ptr_start", 32'(dut.ptr_q), 32'd1);
    apply(0, 4'b0010, 16'h0010, 0);
    check_main("bp w1", 4'b0010, 4'h1, 0);
    apply(0, 4'b0010, 16'h0020, 0);
    check_main("bp w2", 4'b0010, 4'h2, 1);
    check("bp owner", 32'(owner), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 4'b0010, 16'h0030, 1);
      check_main($sformatf("bp stall%0d", i), 4'b0000, 4'h0, 1);
      check($sformatf("bp stall%0d bcnt", i), 32'(dut.bcnt_q), 32'd2);
    end
    apply(0, 4'b0010, 16'h0030, 0);
    check_main("bp w3", 4'b0010, 4'h3, 1);
    apply(0, 4'b0010, 16'h0040, 0);
    check_main("bp w4", 4'b0010, 4'h4, 1);
    check("bp w4 bcnt", 32'(dut.bcnt_q), 32'd3);
    apply(0, 4'b0000, 16'h0000, 0);
    check_main("bp done", 4'b0000, 4'h0, 0);
    check("bp ptr_end", 32'(dut.ptr_q), 32'd2);

    // Reset mid-burst: producer 3 owns with BCNT=2, then RESET for one cycle.
    apply(0, 4'b1000, 16'h9000, 0);
    check_main("rst w1", 4'b1000, 4'h9, 0);
    apply(0, 4'b1000, 16'h9000, 0);
    check_main("rst w2", 4'b1000, 4'h9, 1);
    apply(1, 4'b1001, 16'h9007, 0);
    check("rst owner", 32'(owner), 32'd3);
    check("rst bcnt", 32'(dut.bcnt_q), 32'd2);
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst wr_data", 32'(wr_data), 32'd0);
    apply(0, 4'b1001, 16'h9007, 0);
    check_main("rst after1", 4'b0001, 4'h7, 0);
    check("rst ptr", 32'(dut.ptr_q), 32'd0);
    apply(0, 4'b1001, 16'h9007, 0);
    check_main("rst after2", 4'b0001, 4'h7, 1);

    // MAX_BURST=1 instance: strict alternation between producers 0 and 2.
    apply(1, 4'b0000, 16'h0000, 0);
    for (int i = 0; i < 6; i++) begin
      apply(0, 4'b0101, 16'h0503, 0);
      check($sformatf("mb1 c%0d gnt", i), 32'(gnt1), (i % 2 == 0) ? 32'h1 : 32'h4);
      check($sformatf("mb1 c%0d wr_data", i), 32'(wr_data1), (i % 2 == 0) ? 32'h3 : 32'h5);
      check($sformatf("mb1 c%0d wr_en", i), 32'(wr_en1), 32'd1);
      check($sformatf("mb1 c%0d busy", i), 32'(busy1), 32'd0);
    end

    apply(0, 4'b0000, 16'h0000, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
